// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - MIPS IF-stage program counter with next-PC selection and debug counters
// Optional breakpoint support is enabled by defining PC_BREAKPOINT_EN.
module pc_fetch_ctrl #(
  parameter int len       = 32,
  parameter int MEM_DEPTH = 256,
  parameter int RST_PC    = 0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_enable,
  input  logic           i_stall,
  input  logic [len-1:0] i_pc_adder,
  input  logic           i_branch_taken,
  input  logic [len-1:0] i_branch_target,
  input  logic           i_jump,
  input  logic [len-1:0] i_jump_target,
  input  logic           i_halt_detect,
  output logic [len-1:0] o_pc,
  output logic           o_pc_cte,
  output logic           o_flush,
  output logic           o_instr_valid,
  output logic           o_halted,
  output logic [len-1:0] o_cycle_count,
  output logic [len-1:0] o_fetch_count
`ifdef PC_BREAKPOINT_EN
  ,
  input  logic [len-1:0] i_bp_addr,
  input  logic           i_bp_valid,
  input  logic           i_resume,
  output logic           o_break
`endif
);

  localparam logic [len-1:0] PC_MASK = len'(MEM_DEPTH - 1);
  localparam logic [len-1:0] PC_INIT = len'(RST_PC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
`ifdef PC_BREAKPOINT_EN
    ,
    S_BREAK = 2'd3
`endif
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [len-1:0] r_pc;
  logic [len-1:0] w_pc_nxt;
  logic           r_flush;
  logic           w_flush_nxt;
  logic [len-1:0] r_cycle_count;
  logic [len-1:0] w_cycle_nxt;
  logic [len-1:0] r_fetch_count;
  logic [len-1:0] w_fetch_nxt;
  logic [len-1:0] w_target;
  logic           w_load;
  logic           w_redirect;
  logic           w_run_en;

  assign w_redirect = i_branch_taken | i_jump;
  assign w_run_en   = (r_state == S_RUN) && i_enable;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= PC_INIT;
      r_flush       <= 1'b0;
      r_cycle_count <= '0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_flush       <= w_flush_nxt;
      r_cycle_count <= w_cycle_nxt;
      r_fetch_count <= w_fetch_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_flush_nxt   = r_flush;
    w_cycle_nxt   = r_cycle_count;
    w_fetch_nxt   = r_fetch_count;
    w_target      = i_pc_adder;
    w_load        = 1'b0;
    o_pc_cte      = w_run_en;
    o_instr_valid = w_run_en && !i_stall && !w_redirect;
    case (r_state)
      S_IDLE: begin
        if (i_enable) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_enable) begin
          w_flush_nxt = w_redirect;
          w_cycle_nxt = (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + 1'b1;
          // A redirect beats stall and halt: anything younger is on the wrong path.
          if (i_branch_taken) begin
            w_target = i_branch_target;
            w_load   = 1'b1;
          end else if (i_jump) begin
            w_target = i_jump_target;
            w_load   = 1'b1;
          end else if (i_stall) begin
            w_load   = 1'b0;
          end else if (i_halt_detect) begin
            w_state_nxt = S_HALT;
          end else begin
            w_target = i_pc_adder;
            w_load   = 1'b1;
          end
          if (w_load) begin
            w_pc_nxt    = w_target & PC_MASK;
            w_fetch_nxt = (r_fetch_count == '1) ? r_fetch_count : r_fetch_count + 1'b1;
`ifdef PC_BREAKPOINT_EN
            // Skip when already parked on the address so a resume does not re-trigger.
            if (i_bp_valid && ((w_target & PC_MASK) == i_bp_addr) && (r_pc != i_bp_addr))
              w_state_nxt = S_BREAK;
`endif
          end
        end
      end
`ifdef PC_BREAKPOINT_EN
      S_BREAK: begin
        w_flush_nxt = 1'b0;
        if (i_enable && i_resume) w_state_nxt = S_RUN;
      end
`endif
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  assign o_pc          = r_pc;
  assign o_flush       = r_flush;
  assign o_halted      = (r_state == S_HALT);
  assign o_cycle_count = r_cycle_count;
  assign o_fetch_count = r_fetch_count;
`ifdef PC_BREAKPOINT_EN
  assign o_break       = (r_state == S_BREAK);
`endif

endmodule
